// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - in-order {PC, Instr} FIFO between the IFU and decode
// Fetch is throttled by FQ_o_FetchEn (= !full); a downstream redirect flushes every entry.
module fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              FQ_i_Valid,
    input  logic [31:0]       FQ_i_PC,
    input  logic [31:0]       FQ_i_Instr,
    input  logic              FQ_i_Flush,
    input  logic              FQ_i_DeqReady,
    output logic              FQ_o_FetchEn,
    output logic              FQ_o_Valid,
    output logic [31:0]       FQ_o_PC,
    output logic [31:0]       FQ_o_Instr,
    output logic [ADDR_W:0]   FQ_o_Count
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [63:0]       r_mem [DEPTH];
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W:0]   r_count;

    logic        w_full;
    logic        w_empty;
    logic        w_enq;
    logic        w_deq;
    logic [63:0] w_head;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);
    // Refusing enq whenever full keeps FetchEn free of any path from DeqReady.
    assign w_enq   = FQ_i_Valid && !w_full;
    assign w_deq   = !w_empty && FQ_i_DeqReady;
    assign w_head  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || FQ_i_Flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; stale words are masked by the empty check on the outputs.
    always_ff @(posedge clk) begin
        if (!reset && !FQ_i_Flush && w_enq) begin
            r_mem[r_wr_ptr] <= {FQ_i_PC, FQ_i_Instr};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (r_count <= FULL_CNT);
        end
    end

    assign FQ_o_FetchEn = !w_full;
    assign FQ_o_Valid   = !w_empty;
    assign FQ_o_PC      = w_empty ? 32'd0 : w_head[63:32];
    assign FQ_o_Instr   = w_empty ? 32'd0 : w_head[31:0];
    assign FQ_o_Count   = r_count;

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - scoreboard bench for fetch_queue
module tb_fetch_queue;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    logic              clk;
    logic              reset;
    logic              fq_valid;
    logic [31:0]       fq_pc;
    logic [31:0]       fq_instr;
    logic              fq_flush;
    logic              fq_deq_ready;
    logic              fq_fetch_en;
    logic              fq_o_valid;
    logic [31:0]       fq_o_pc;
    logic [31:0]       fq_o_instr;
    logic [ADDR_W:0]   fq_o_count;

    int checks;
    int failures;

    logic [63:0] exp_q[$];

    fetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .FQ_i_Valid    (fq_valid),
        .FQ_i_PC       (fq_pc),
        .FQ_i_Instr    (fq_instr),
        .FQ_i_Flush    (fq_flush),
        .FQ_i_DeqReady (fq_deq_ready),
        .FQ_o_FetchEn  (fq_fetch_en),
        .FQ_o_Valid    (fq_o_valid),
        .FQ_o_PC       (fq_o_pc),
        .FQ_o_Instr    (fq_o_instr),
        .FQ_o_Count    (fq_o_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle: check outputs against the model before the edge, then advance the model.
    task automatic cycle(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                         input logic rdy, input logic fl, input logic rst);
        int  cnt;
        logic do_enq;
        logic do_deq;
        logic [63:0] head;
        fq_valid     = v;
        fq_pc        = pc;
        fq_instr     = instr;
        fq_deq_ready = rdy;
        fq_flush     = fl;
        reset        = rst;
        #1;
        cnt  = exp_q.size();
        head = (cnt != 0) ? exp_q[0] : 64'd0;
        check_val("count",    64'(fq_o_count), 64'(cnt));
        check_val("valid",    64'(fq_o_valid), 64'(cnt != 0));
        check_val("fetch_en", 64'(fq_fetch_en), 64'(cnt != DEPTH));
        check_val("head_pc",    64'(fq_o_pc),    64'(head[63:32]));
        check_val("head_instr", 64'(fq_o_instr), 64'(head[31:0]));
        do_enq = v && (cnt != DEPTH);
        do_deq = rdy && (cnt != 0);
        if (rst || fl) begin
            exp_q.delete();
        end else begin
            if (do_deq) begin
                void'(exp_q.pop_front());
            end
            if (do_enq) begin
                exp_q.push_back({pc, instr});
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input logic rdy);
        cycle(1'b0, 32'd0, 32'd0, rdy, 1'b0, 1'b0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset        = 1'b1;
        fq_valid     = 1'b0;
        fq_pc        = '0;
        fq_instr     = '0;
        fq_flush     = 1'b0;
        fq_deq_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset values
        idle(1'b0);

        // Fill past full: 0x3010 must be refused
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 32'h3000 + 32'(4 * i), 32'h2408_0000 + 32'(i), 1'b0, 1'b0, 1'b0);
        end
        // Full with DeqReady and Valid: dequeue only
        cycle(1'b1, 32'h3014, 32'h2408_0005, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            idle(1'b1);
        end

        // Empty: no bypass, word visible after the edge
        cycle(1'b1, 32'h3000, 32'h2408_0001, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b0);

        // Steady stream through pointer wrap
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 32'h3000 + 32'(4 * i), $urandom, 1'b1, 1'b0, 1'b0);
        end
        idle(1'b1);
        idle(1'b0);

        // Flush with simultaneous enq and deq
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 32'h3100 + 32'(4 * i), $urandom, 1'b0, 1'b0, 1'b0);
        end
        cycle(1'b1, 32'h3200, 32'h1111_1111, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 32'h3400, 32'h2222_2222, 1'b0, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b0);

        // Reset with enqueue, then restart from slot 0
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 32'h3500 + 32'(4 * i), $urandom, 1'b0, 1'b0, 1'b0);
        end
        cycle(1'b1, 32'h3600, 32'h3333_3333, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 32'h3700 + 32'(4 * i), $urandom, (i >= 3) ? 1'b1 : 1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 5; i++) begin
            idle(1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Small in-order FIFO between the IFU and the decode stage; buffers {PC, Instr} pairs so fetch continues while decode stalls.
- Drives the IFU enable: fetch advances only when the queue has room.
- Flushed wholesale when a branch or jump redirect is taken downstream.

Parameters:
- DEPTH, 4, number of entries; must be a power of two and at least 2.
- ADDR_W, 2, log2(DEPTH); pointer width.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- FQ_i_Valid  input  1  IFU presents a valid fetched word this cycle.
- FQ_i_PC  input  32  PC of the fetched word.
- FQ_i_Instr  input  32  fetched instruction word.
- FQ_i_Flush  input  1  discard all entries, including any same-cycle enqueue.
- FQ_i_DeqReady  input  1  decode accepts the head entry this cycle.
- FQ_o_FetchEn  output  1  enable to the IFU PC register; equals !full.
- FQ_o_Valid  output  1  head entry valid; equals count != 0.
- FQ_o_PC  output  32  PC of head entry; 0 when empty.
- FQ_o_Instr  output  32  instruction of head entry; 0 (nop) when empty.
- FQ_o_Count  output  ADDR_W+1  number of occupied entries, 0..DEPTH.

Behaviour:
State and storage:
- Storage is DEPTH x 64 bits ({PC, Instr}), plus rd_ptr, wr_ptr (ADDR_W bits, natural wrap) and count (ADDR_W+1 bits).
- full = (count == DEPTH); empty = (count == 0).

Transfers:
- enq = FQ_i_Valid && !full.
- deq = !empty && FQ_i_DeqReady.
- FQ_i_DeqReady while empty is ignored.

On posedge, priority reset > flush > normal:
- reset: rd_ptr = wr_ptr = 0; count = 0. Storage contents are don't-care.
- FQ_i_Flush: rd_ptr = wr_ptr = 0; count = 0. A simultaneous enq and deq are both discarded.
- Normal operation:
  - enq writes mem[wr_ptr] and sets wr_ptr += 1.
  - deq sets rd_ptr += 1.
  - count += enq - deq, so simultaneous enq and deq leave count unchanged.

Full and empty corner cases:
- When full, enq is refused even if a deq occurs the same cycle. FetchEn is a pure function of registered state, with no combinational path from DeqReady to FetchEn.
- When empty, there is no bypass: an entry written at edge N is first visible on FQ_o_* after edge N. Minimum fetch-to-decode latency is one cycle.
- Wrap-around: pointers wrap modulo DEPTH with no special handling. Ordering is strictly FIFO across the wrap.

Outputs:
- All outputs are combinational from registered state.
- FQ_o_PC and FQ_o_Instr are read from mem[rd_ptr] when !empty, and forced to 0 when empty.
- Reset values: FetchEn = 1, Valid = 0, PC = 0, Instr = 0, Count = 0.
- The output word is stable while Valid && !DeqReady, since head data only changes on deq.

Sanity check:
- Simulation-only: an error triggers if count > DEPTH.

Test Plan:
1. Reset, then FQ_i_Valid=1 with PCs 0x3000, 0x3004, 0x3008, 0x300C, 0x3010 on consecutive cycles, DeqReady=0 -> Count climbs 1..4; FetchEn=0 after the 4th edge; the 0x3010 word is not stored; head PC = 0x3000.
2. From full, DeqReady=1 with Valid=1 held for one cycle -> Count goes 4→3 (no enqueue that cycle); head PC becomes 0x3004; FetchEn=1.
3. Empty queue, Valid=1 and DeqReady=1 with PC=0x3000, Instr=0x24080001 -> the same cycle shows Valid=0 and Instr=0. After the edge: Valid=1, PC=0x3000, Instr=0x24080001.
4. Steady stream with Valid=1 and DeqReady=1 for 10 cycles from 0x3000 -> Count holds 1; decode sees 0x3000..0x3024 in order with pointers wrapping twice; no drops or duplicates.
5. Count=3, then Flush=1 together with Valid=1 and DeqReady=1 -> next cycle Count=0, Valid=0, FetchEn=1, PC=0. The next enqueued word (PC 0x3400) appears as head.
6. Count=2, then reset=1 together with Valid=1 -> next cycle all outputs at reset values. Deasserting reset restarts normal enqueue from slot 0.
